// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-requester AXI4 arbiter: IFU (read) and LSU (read/write) share one downstream master port.
// One transaction in flight; grant is registered and held until the final response handshake.
module ysyx_24100006_axi_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rlast,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,

    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rlast,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [2:0]          lsu_awsize,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,

    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awsize,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,

    output logic                grant_ifu
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               ar_done_q, ar_done_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic               starved;

    assign starved = ifu_arvalid && (starve_cnt_q == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    // Arbitration and transaction tracking; IDLE always separates two grants
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        case (state_q)
            IDLE: begin
                if (starved) begin
                    state_d      = RD_IFU;
                    starve_cnt_d = '0;
                end else if (lsu_awvalid || lsu_arvalid) begin
                    state_d = lsu_awvalid ? WR : RD_LSU;
                    if (ifu_arvalid && (starve_cnt_q != CNT_W'(STARVE_MAX)))
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end else if (ifu_arvalid) begin
                    state_d      = RD_IFU;
                    starve_cnt_d = '0;
                end
            end
            RD_IFU, RD_LSU: begin
                if (m_arvalid && m_arready)
                    ar_done_d = 1'b1;
                if (m_rvalid && m_rready && m_rlast) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            WR: begin
                if (m_awvalid && m_awready)
                    aw_done_d = 1'b1;
                if (m_wvalid && m_wready && m_wlast)
                    w_done_d = 1'b1;
                if (m_bvalid && m_bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel routing: only the owner sees the downstream bus, everything else is held at 0
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        ifu_rlast   = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_rlast   = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;
        m_araddr    = '0;
        m_arlen     = 8'd0;
        m_arsize    = 3'd0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awaddr    = '0;
        m_awsize    = 3'd0;
        m_awvalid   = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wlast     = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        grant_ifu   = (state_q == RD_IFU);
        case (state_q)
            RD_IFU: begin
                m_araddr    = ifu_araddr;
                m_arlen     = ifu_arlen;
                m_arsize    = ifu_arsize;
                m_arvalid   = ifu_arvalid & ~ar_done_q;
                ifu_arready = m_arready & ~ar_done_q;
                ifu_rdata   = m_rdata;
                ifu_rresp   = m_rresp;
                ifu_rlast   = m_rlast;
                ifu_rvalid  = m_rvalid;
                m_rready    = ifu_rready;
            end
            RD_LSU: begin
                m_araddr    = lsu_araddr;
                m_arlen     = lsu_arlen;
                m_arsize    = lsu_arsize;
                m_arvalid   = lsu_arvalid & ~ar_done_q;
                lsu_arready = m_arready & ~ar_done_q;
                lsu_rdata   = m_rdata;
                lsu_rresp   = m_rresp;
                lsu_rlast   = m_rlast;
                lsu_rvalid  = m_rvalid;
                m_rready    = lsu_rready;
            end
            WR: begin
                m_awaddr    = lsu_awaddr;
                m_awsize    = lsu_awsize;
                m_awvalid   = lsu_awvalid & ~aw_done_q;
                lsu_awready = m_awready & ~aw_done_q;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                m_wlast     = lsu_wlast;
                m_wvalid    = lsu_wvalid & ~w_done_q;
                lsu_wready  = m_wready & ~w_done_q;
                lsu_bresp   = m_bresp;
                lsu_bvalid  = m_bvalid;
                m_bready    = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter; the bench itself plays the downstream slave.
module tb_ysyx_24100006_axi_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] ifu_araddr;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic        ifu_arvalid, ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rlast, ifu_rvalid, ifu_rready;
    logic [31:0] lsu_araddr;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic        lsu_arvalid, lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rlast, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_awaddr;
    logic [2:0]  lsu_awsize;
    logic        lsu_awvalid, lsu_awready;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wlast, lsu_wvalid, lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast, m_rvalid, m_rready;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awsize;
    logic        m_awvalid, m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic        grant_ifu;

    int total = 0;
    int bad   = 0;

    ysyx_24100006_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize), .lsu_awvalid(lsu_awvalid),
        .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid),
        .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant_ifu(grant_ifu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = 3'd2; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
        lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = 3'd2; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        lsu_awaddr = '0; lsu_awsize = 3'd2; lsu_awvalid = 1'b0;
        lsu_wdata = '0; lsu_wstrb = '0; lsu_wlast = 1'b0; lsu_wvalid = 1'b0; lsu_bready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;

        // Reset: requests and slave readiness present, yet every output stays 0
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; m_arready = 1'b1;
        cyc(); cyc();
        chk("rst_grant_ifu", 32'(grant_ifu), 0);
        chk("rst_m_arvalid", 32'(m_arvalid), 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_ifu_arready", 32'(ifu_arready), 0);
        reset = 1'b1;
        m_arready = 1'b0;

        // IFU-only read with 3 idle cycles before data
        cyc();
        chk("t1_grant", 32'(grant_ifu), 1);
        chk("t1_m_arvalid", 32'(m_arvalid), 1);
        chk("t1_m_araddr", m_araddr, 32'h8000_0000);
        chk("t1_lsu_arready", 32'(lsu_arready), 0);
        m_arready = 1'b1; #1;
        chk("t1_ifu_arready", 32'(ifu_arready), 1);
        cyc();
        chk("t1_arvalid_masked", 32'(m_arvalid), 0);
        chk("t1_arready_masked", 32'(ifu_arready), 0);
        ifu_arvalid = 1'b0; m_arready = 1'b0;
        cyc(); cyc();
        chk("t1_grant_hold", 32'(grant_ifu), 1);
        m_rvalid = 1'b1; m_rdata = 32'h0000_0413; m_rlast = 1'b1; m_rresp = 2'b00; ifu_rready = 1'b1; #1;
        chk("t1_ifu_rvalid", 32'(ifu_rvalid), 1);
        chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_lsu_rvalid", 32'(lsu_rvalid), 0);
        chk("t1_m_rready", 32'(m_rready), 1);
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0; ifu_rready = 1'b0; #1;
        chk("t1_idle", 32'(grant_ifu), 0);
        chk("t1_ifu_rvalid_off", 32'(ifu_rvalid), 0);

        // Simultaneous IFU and LSU read: LSU first, IFU after the idle cycle
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0004;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0010;
        cyc();
        chk("t2_lsu_first", 32'(grant_ifu), 0);
        chk("t2_m_araddr", m_araddr, 32'h0F00_0010);
        m_arready = 1'b1; #1;
        chk("t2_lsu_arready", 32'(lsu_arready), 1);
        chk("t2_ifu_arready", 32'(ifu_arready), 0);
        cyc();
        lsu_arvalid = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h1234_5678; lsu_rready = 1'b1; #1;
        chk("t2_lsu_rdata", lsu_rdata, 32'h1234_5678);
        chk("t2_ifu_rvalid", 32'(ifu_rvalid), 0);
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0; lsu_rready = 1'b0; m_arready = 1'b1; #1;
        chk("t2_gap_no_grant", 32'(grant_ifu), 0);
        chk("t2_gap_arvalid", 32'(m_arvalid), 0);
        chk("t2_gap_ifu_arready", 32'(ifu_arready), 0);
        cyc();
        chk("t2_ifu_grant", 32'(grant_ifu), 1);
        chk("t2_ifu_araddr", m_araddr, 32'h8000_0004);
        chk("t2_ifu_arready", 32'(ifu_arready), 1);
        cyc();
        ifu_arvalid = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rlast = 1'b1; ifu_rready = 1'b1;
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0; ifu_rready = 1'b0;

        // LSU write with W offered 3 cycles before AW
        lsu_wvalid = 1'b1; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hF; lsu_wlast = 1'b1;
        m_wready = 1'b1;
        cyc(); cyc();
        chk("t3_w_blocked", 32'(m_wvalid), 0);
        chk("t3_wready_blocked", 32'(lsu_wready), 0);
        cyc();
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h0F00_0020;
        cyc();
        chk("t3_m_wvalid", 32'(m_wvalid), 1);
        chk("t3_m_wdata", m_wdata, 32'hCAFE_F00D);
        chk("t3_lsu_wready", 32'(lsu_wready), 1);
        chk("t3_m_awvalid", 32'(m_awvalid), 1);
        chk("t3_lsu_awready_wait", 32'(lsu_awready), 0);
        cyc();
        lsu_wvalid = 1'b0; #1;
        chk("t3_w_masked_ready", 32'(lsu_wready), 0);
        m_awready = 1'b1; #1;
        chk("t3_lsu_awready", 32'(lsu_awready), 1);
        chk("t3_m_awaddr", m_awaddr, 32'h0F00_0020);
        cyc();
        chk("t3_aw_masked", 32'(m_awvalid), 0);
        lsu_awvalid = 1'b0; m_awready = 1'b0;
        m_bvalid = 1'b1; m_bresp = 2'b00; lsu_bready = 1'b1; #1;
        chk("t3_lsu_bvalid", 32'(lsu_bvalid), 1);
        chk("t3_lsu_bresp", 32'(lsu_bresp), 0);
        chk("t3_m_bready", 32'(m_bready), 1);
        cyc();
        m_bvalid = 1'b0; lsu_bready = 1'b0; m_wready = 1'b0; #1;
        chk("t3_state_idle", 32'(dut.state_q), 0);
        chk("t3_lsu_bvalid_off", 32'(lsu_bvalid), 0);

        // Starvation: IFU waits through 4 LSU grants, then wins; LSU keeps requesting
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0100;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0040;
        ifu_rready = 1'b1; lsu_rready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("t4_owner", 32'(grant_ifu), (i == 4) ? 32'd1 : 32'd0);
            chk("t4_starve_cnt", 32'(dut.starve_cnt_q), (i < 4) ? 32'(i + 1) : 32'd0);
            m_arready = 1'b1;
            cyc();
            m_arready = 1'b0;
            if (i == 4) ifu_arvalid = 1'b0;
            m_rvalid = 1'b1; m_rlast = 1'b1;
            cyc();
            m_rvalid = 1'b0; m_rlast = 1'b0;
        end
        lsu_arvalid = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
        cyc();
        chk("t4_starve_after", 32'(dut.starve_cnt_q), 0);

        // IFU burst of 4 beats with a consumer stall on every beat
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0200; ifu_arlen = 8'd3;
        cyc();
        chk("t5_grant", 32'(grant_ifu), 1);
        chk("t5_m_arlen", 32'(m_arlen), 3);
        m_arready = 1'b1;
        cyc();
        ifu_arvalid = 1'b0; m_arready = 1'b0; ifu_arlen = 8'd0;
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1; m_rdata = 32'h100 + 32'(b); m_rlast = (b == 3); ifu_rready = 1'b0; #1;
            chk("t5_stall_rready", 32'(m_rready), 0);
            cyc();
            chk("t5_stall_hold", 32'(grant_ifu), 1);
            ifu_rready = 1'b1; #1;
            chk("t5_rdata", ifu_rdata, 32'h100 + 32'(b));
            chk("t5_rlast", 32'(ifu_rlast), (b == 3) ? 32'd1 : 32'd0);
            cyc();
            chk("t5_after_beat", 32'(grant_ifu), (b == 3) ? 32'd0 : 32'd1);
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; ifu_rready = 1'b0;

        // Access fault propagated to the LSU
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0000;
        cyc();
        m_arready = 1'b1;
        cyc();
        lsu_arvalid = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rresp = 2'b11; lsu_rready = 1'b1; #1;
        chk("t6_lsu_rresp", 32'(lsu_rresp), 32'h3);
        chk("t6_ifu_rresp", 32'(ifu_rresp), 0);
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; lsu_rready = 1'b0;

        // Reset mid RD_IFU, then both requesters pending: LSU wins first
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0300;
        cyc();
        chk("t7_pre_grant", 32'(grant_ifu), 1);
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0080; m_arready = 1'b1;
        #2; reset = 1'b0; #1;
        chk("t7_rst_grant", 32'(grant_ifu), 0);
        chk("t7_rst_m_arvalid", 32'(m_arvalid), 0);
        chk("t7_rst_m_araddr", m_araddr, 0);
        chk("t7_rst_ifu_arready", 32'(ifu_arready), 0);
        cyc();
        reset = 1'b1; m_arready = 1'b0;
        cyc();
        chk("t7_post_lsu", 32'(grant_ifu), 0);
        chk("t7_post_araddr", m_araddr, 32'h0F00_0080);
        chk("t7_post_starve", 32'(dut.starve_cnt_q), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_axi_arbiter.md
Name: ysyx_24100006_axi_arbiter

Overview:
Shares the single downstream AXI4 master port between the instruction-fetch unit (read-only) and the load/store unit (read and write). Grants one transaction at a time, holds the grant until the final response handshake, and routes responses and fault codes back to the owner. It sits between the IFU/LSU and the SoC crossbar, and is the only block that drives the external bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, number of consecutive LSU grants after which a waiting IFU read wins

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ifu_araddr, ifu_arlen, ifu_arsize  in  32/8/3  IFU read address channel payload
ifu_arvalid  in  1  IFU read request
ifu_arready  out  1  IFU read address accepted
ifu_rdata, ifu_rresp, ifu_rlast  out  32/2/1  IFU read data channel payload
ifu_rvalid  out  1  IFU read data valid
ifu_rready  in  1  IFU ready for read data
lsu_araddr, lsu_arlen, lsu_arsize, lsu_arvalid  in  32/8/3/1  LSU read address channel
lsu_arready  out  1  LSU read address accepted
lsu_rdata, lsu_rresp, lsu_rlast, lsu_rvalid  out  32/2/1/1  LSU read data channel
lsu_rready  in  1  LSU ready for read data
lsu_awaddr, lsu_awsize, lsu_awvalid  in  32/3/1  LSU write address channel
lsu_awready  out  1  LSU write address accepted
lsu_wdata, lsu_wstrb, lsu_wlast, lsu_wvalid  in  32/4/1/1  LSU write data channel
lsu_wready  out  1  LSU write data accepted
lsu_bresp, lsu_bvalid  out  2/1  LSU write response
lsu_bready  in  1  LSU ready for write response
m_ar*, m_r*, m_aw*, m_w*, m_b*  mixed  per channel  downstream AXI4 master: araddr/arlen/arsize/arvalid out, arready in; rdata/rresp/rlast/rvalid in, rready out; awaddr/awsize/awvalid out, awready in; wdata/wstrb/wlast/wvalid out, wready in; bresp/bvalid in, bready out
grant_ifu  out  1  debug: IFU owns the bus

Behaviour:
- States: IDLE, RD_IFU, RD_LSU, WR. Reset (reset=0, asynchronous) forces IDLE, starve_cnt=0, aw_done=0, w_done=0.
- While reset is asserted and in IDLE, all valid/ready outputs upstream and downstream are 0, grant_ifu=0, and payload outputs are 0.
- IDLE arbitration happens at a clock edge, with registered grant and one cycle of arbitration latency. Priority:
  - LSU write (lsu_awvalid) > LSU read > IFU read.
  - Exception: if ifu_arvalid=1 and starve_cnt==STARVE_MAX, IFU wins.
- starve_cnt: incremented on each LSU grant while ifu_arvalid=1; cleared on any IFU grant; saturates at STARVE_MAX.
- RD_x:
  - The m_ar channel is combinationally connected to requester x, and the other requester's arready=0.
  - After the AR handshake, m_arvalid is masked to 0 until the state is left.
  - The m_r channel is routed to x, with m_rready = x_rready.
  - The transaction ends on m_rvalid & m_rready & m_rlast, returning to IDLE the next cycle.
- WR:
  - AW and W are forwarded independently. aw_done and w_done are set on their handshakes, which mask the corresponding valid.
  - B is routed to the LSU.
  - On the B handshake, return to IDLE and clear both flags.
- Only one outstanding transaction exists. A new grant is never issued in the same cycle as a final handshake.
- The non-owner always sees ready=0 and valid=0 on every channel.
- rresp and bresp pass through unmodified (2'b10 and 2'b11 mean access fault, consumed by the requester).
- An IFU request withdrawn before grant is legal and ignored. Requests withdrawn after grant are illegal (AXI rule).
- Bursts: arlen is passed through and beats are forwarded until rlast. Beat count is not checked.
- An asynchronous reset mid-transaction aborts immediately to IDLE. The downstream slave is reset by the same signal.

Test Plan:
- IFU-only reads: ifu_araddr=0x80000000, slave returns 0x00000413 after 3 cycles -> ifu_rvalid=1 with rdata=0x00000413, lsu_* valids stay 0, grant_ifu=1 for the whole transaction.
- Simultaneous IFU read and LSU read in the same cycle -> LSU granted first; IFU ar handshake occurs only after LSU rlast handshake plus 1 cycle.
- LSU write with W before AW: wvalid cycle 0, awvalid cycle 3 -> m_wvalid accepted first, aw later, single b routed to lsu_bresp=2'b00, state returns IDLE.
- Starvation: LSU issues 6 back-to-back reads while IFU holds arvalid, STARVE_MAX=4 -> IFU granted after the 4th LSU transaction; starve_cnt reads 0 afterwards.
- Burst read arlen=3 for IFU -> 4 beats forwarded, only the 4th has rlast; state stays RD_IFU until then, with ifu_rready=0 stalls honoured.
- Fault plus reset: slave returns rresp=2'b11 to LSU -> lsu_rresp=2'b11 is delivered. Asserting reset low mid-RD_IFU -> all outputs 0 within the same cycle, and the first post-reset grant follows IDLE priority.
